// File: rtl/pn_gen_cfg.sv
// pn_gen_cfg: PN-sequence generator with a length, polynomial, seed and
// mode (Fibonacci or Galois) that can be changed at run time. It also
// guards against all-zero lock-up and measures the sequence period.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   load         in   capture cfg_* and restart from the seed (wins over en)
//   cfg_n        in   register length N, clamped to 2..MAX_N when loaded
//   cfg_poly     in   characteristic polynomial (bit i = tap on state[i])
//   cfg_seed     in   initial state
//   cfg_mode     in   0 = Fibonacci, 1 = Galois
//   en           in   advance one step this cycle
//   seq          out  current state; bits >= N are always 0
//   out_bit      out  seq[0]
//   lockup       out  sticky: the last loaded seed was zero after masking
//   period_done  out  one-cycle pulse when the state returns to the seed
//   period_len   out  steps in the last completed period (saturating)
module pn_gen_cfg #(
    parameter int               MAX_N        = 16,
    parameter int               DEFAULT_N    = 4,
    parameter logic [MAX_N-1:0] DEFAULT_POLY = 16'h0003
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [4:0]       cfg_n,
    input  logic [MAX_N-1:0] cfg_poly,
    input  logic [MAX_N-1:0] cfg_seed,
    input  logic             cfg_mode,
    input  logic             en,
    output logic [MAX_N-1:0] seq,
    output logic             out_bit,
    output logic             lockup,
    output logic             period_done,
    output logic [MAX_N-1:0] period_len
);

    localparam logic [MAX_N-1:0] ONE     = 1;
    localparam logic [MAX_N:0]   ONE_W   = 1;
    localparam logic [4:0]       N_MIN   = 5'd2;
    localparam logic [4:0]       N_MAX   = 5'(MAX_N);
    localparam logic [4:0]       N_RESET = 5'(DEFAULT_N);

    logic [MAX_N-1:0] seq_q, seq_d;
    logic [4:0]       n_q, n_d;
    logic [MAX_N-1:0] poly_q, poly_d;
    logic [MAX_N-1:0] seed_q, seed_d;
    logic             mode_q, mode_d;
    logic [MAX_N-1:0] step_cnt_q, step_cnt_d;
    logic [MAX_N-1:0] period_len_q, period_len_d;
    logic             lockup_q, lockup_d;
    logic             period_done_q, period_done_d;

    // One extra bit so that N = MAX_N yields an all-ones mask.
    function automatic logic [MAX_N-1:0] len_mask(input logic [4:0] n);
        logic [MAX_N:0] w;
        w = (ONE_W << n) - ONE_W;
        return w[MAX_N-1:0];
    endfunction

    logic [4:0]       load_n;
    logic [MAX_N-1:0] load_mask;
    logic [MAX_N-1:0] load_seed;
    logic [MAX_N-1:0] top_bit;
    logic [MAX_N-1:0] fib_next;
    logic [MAX_N-1:0] gal_next;
    logic [MAX_N-1:0] step_next;
    logic [MAX_N-1:0] cnt_inc;

    always_comb begin
        seq_d         = seq_q;
        n_d           = n_q;
        poly_d        = poly_q;
        seed_d        = seed_q;
        mode_d        = mode_q;
        step_cnt_d    = step_cnt_q;
        period_len_d  = period_len_q;
        lockup_d      = lockup_q;
        period_done_d = 1'b0;

        if (cfg_n < N_MIN) begin
            load_n = N_MIN;
        end else if (cfg_n > N_MAX) begin
            load_n = N_MAX;
        end else begin
            load_n = cfg_n;
        end
        load_mask = len_mask(load_n);
        load_seed = cfg_seed & load_mask;

        // seq_q never has bits >= N set, so the shifted value leaves
        // position N-1 free for the Fibonacci feedback bit.
        top_bit   = ONE << (n_q - 5'd1);
        fib_next  = (seq_q >> 1) | ((^(seq_q & poly_q)) ? top_bit : '0);
        gal_next  = (seq_q >> 1) ^ ({MAX_N{seq_q[0]}} & (poly_q | top_bit));
        step_next = (mode_q ? gal_next : fib_next) & len_mask(n_q);
        cnt_inc   = (&step_cnt_q) ? step_cnt_q : step_cnt_q + ONE;

        if (load) begin
            n_d        = load_n;
            poly_d     = cfg_poly & load_mask;
            mode_d     = cfg_mode;
            step_cnt_d = '0;
            if (load_seed == '0) begin
                seed_d   = ONE;
                seq_d    = ONE;
                lockup_d = 1'b1;
            end else begin
                seed_d   = load_seed;
                seq_d    = load_seed;
                lockup_d = 1'b0;
            end
        end else if (en) begin
            seq_d = step_next;
            if (step_next == seed_q) begin
                period_done_d = 1'b1;
                period_len_d  = cnt_inc;
                step_cnt_d    = '0;
            end else begin
                step_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q         <= ONE;
            n_q           <= N_RESET;
            poly_q        <= DEFAULT_POLY;
            seed_q        <= ONE;
            mode_q        <= 1'b0;
            step_cnt_q    <= '0;
            period_len_q  <= '0;
            lockup_q      <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            seq_q         <= seq_d;
            n_q           <= n_d;
            poly_q        <= poly_d;
            seed_q        <= seed_d;
            mode_q        <= mode_d;
            step_cnt_q    <= step_cnt_d;
            period_len_q  <= period_len_d;
            lockup_q      <= lockup_d;
            period_done_q <= period_done_d;
        end
    end

    assign seq         = seq_q;
    assign out_bit     = seq_q[0];
    assign lockup      = lockup_q;
    assign period_done = period_done_q;
    assign period_len  = period_len_q;

endmodule

// File: tb/tb_pn_gen_cfg.sv
// Testbench for pn_gen_cfg. It uses a vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_pn_gen_cfg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  cfg_n = '0;
    logic [15:0] cfg_poly = '0;
    logic [15:0] cfg_seed = '0;
    logic        cfg_mode = 1'b0;
    logic        en = 1'b0;
    logic [15:0] seq;
    logic        out_bit;
    logic        lockup;
    logic        period_done;
    logic [15:0] period_len;

    int n_cmp = 0;
    int n_err = 0;

    pn_gen_cfg #(.MAX_N(16), .DEFAULT_N(4), .DEFAULT_POLY(16'h0003)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .cfg_n(cfg_n),
        .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_mode(cfg_mode),
        .en(en), .seq(seq), .out_bit(out_bit), .lockup(lockup),
        .period_done(period_done), .period_len(period_len)
    );

    always #5 clk = ~clk;

    // Behavioural model. The state is an integer. Each step applies the
    // stated shift rule. The period is measured by counting steps since
    // the state last matched the seed.
    int          m_n;
    logic [15:0] m_poly, m_seed, m_seq, m_cnt, m_len;
    logic        m_mode, m_lock, m_done;

    task automatic m_reset();
        m_n = 4; m_poly = 16'h3; m_seed = 16'h1; m_seq = 16'h1; m_mode = 1'b0;
        m_cnt = 0; m_len = 0; m_lock = 1'b0; m_done = 1'b0;
    endtask

    function automatic logic [15:0] m_next(input logic [15:0] s);
        int          mask;
        int          fb;
        logic [15:0] r;
        mask = (1 << m_n) - 1;
        if (!m_mode) begin
            fb = $countones(s & m_poly) % 2;
            r  = (s >> 1) | (16'(fb) << (m_n - 1));
        end else begin
            r = (s >> 1) ^ (s[0] ? (m_poly | (16'd1 << (m_n - 1))) : 16'd0);
        end
        return r & 16'(mask);
    endfunction

    task automatic m_edge();
        int          nn;
        int          mask;
        logic [15:0] nx;
        logic [15:0] inc;
        if (load) begin
            nn = int'(cfg_n);
            if (nn < 2) nn = 2;
            if (nn > 16) nn = 16;
            mask   = (1 << nn) - 1;
            m_n    = nn;
            m_poly = cfg_poly & 16'(mask);
            m_seed = cfg_seed & 16'(mask);
            m_mode = cfg_mode;
            if (m_seed == 0) begin m_seed = 1; m_lock = 1'b1; end
            else m_lock = 1'b0;
            m_seq = m_seed; m_cnt = 0; m_done = 1'b0;
        end else if (en) begin
            nx  = m_next(m_seq);
            inc = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
            if (nx == m_seed) begin
                m_done = 1'b1; m_len = inc; m_cnt = 0;
            end else begin
                m_done = 1'b0; m_cnt = inc;
            end
            m_seq = nx;
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".seq"}, 32'(seq), 32'(m_seq));
        check({tag, ".out_bit"}, 32'(out_bit), 32'(m_seq[0]));
        check({tag, ".lockup"}, 32'(lockup), 32'(m_lock));
        check({tag, ".period_done"}, 32'(period_done), 32'(m_done));
        check({tag, ".period_len"}, 32'(period_len), 32'(m_len));
    endtask

    task automatic cyc(input string tag);
        m_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_load(input logic [4:0] n, input logic [15:0] p, input logic [15:0] s,
                           input logic m, input logic e);
        load = 1'b1; cfg_n = n; cfg_poly = p; cfg_seed = s; cfg_mode = m; en = e;
        cyc("load");
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0] seq;
        logic        ob;
        logic        done;
        logic [15:0] len;
    } vec_t;

    vec_t tv[15];
    int   ob2[15];

    initial begin
        int first_done;

        tv[0]  = '{16'h8, 1'b0, 1'b0, 16'd0};
        tv[1]  = '{16'h4, 1'b0, 1'b0, 16'd0};
        tv[2]  = '{16'h2, 1'b0, 1'b0, 16'd0};
        tv[3]  = '{16'h9, 1'b1, 1'b0, 16'd0};
        tv[4]  = '{16'hC, 1'b0, 1'b0, 16'd0};
        tv[5]  = '{16'h6, 1'b0, 1'b0, 16'd0};
        tv[6]  = '{16'hB, 1'b1, 1'b0, 16'd0};
        tv[7]  = '{16'h5, 1'b1, 1'b0, 16'd0};
        tv[8]  = '{16'hA, 1'b0, 1'b0, 16'd0};
        tv[9]  = '{16'hD, 1'b1, 1'b0, 16'd0};
        tv[10] = '{16'hE, 1'b0, 1'b0, 16'd0};
        tv[11] = '{16'hF, 1'b1, 1'b0, 16'd0};
        tv[12] = '{16'h7, 1'b1, 1'b0, 16'd0};
        tv[13] = '{16'h3, 1'b1, 1'b0, 16'd0};
        tv[14] = '{16'h1, 1'b1, 1'b1, 16'd15};
        ob2 = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1};

        // Reset state
        m_reset();
        #12;
        check("rst.seq", 32'(seq), 32'h1);
        check("rst.lockup", 32'(lockup), 32'h0);
        check("rst.period_done", 32'(period_done), 32'h0);
        check("rst.period_len", 32'(period_len), 32'h0);
        reset_n = 1'b1;
        cyc("idle");

        // Fibonacci N=4, poly 0x3, seed 1: vector table
        do_load(5'd4, 16'h3, 16'h1, 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            m_edge();
            @(posedge clk);
            #1;
            check($sformatf("tv%0d.seq", i), 32'(seq), 32'(tv[i].seq));
            check($sformatf("tv%0d.out_bit", i), 32'(out_bit), 32'(tv[i].ob));
            check($sformatf("tv%0d.period_done", i), 32'(period_done), 32'(tv[i].done));
            check($sformatf("tv%0d.period_len", i), 32'(period_len), 32'(tv[i].len));
        end

        // out_bit stream from the load, across two periods
        do_load(5'd4, 16'h3, 16'h1, 1'b0, 1'b0);
        check("ob.0", 32'(out_bit), 32'(ob2[0]));
        en = 1'b1;
        for (int i = 1; i < 30; i++) begin
            cyc("ob_run");
            check($sformatf("ob.%0d", i), 32'(out_bit), 32'(ob2[i % 15]));
        end

        // Lock-up guard
        do_load(5'd4, 16'h3, 16'h0, 1'b0, 1'b0);
        check("lock.seq", 32'(seq), 32'h1);
        check("lock.lockup", 32'(lockup), 32'h1);
        do_load(5'd4, 16'h3, 16'h5, 1'b0, 1'b0);
        check("unlock.seq", 32'(seq), 32'h5);
        check("unlock.lockup", 32'(lockup), 32'h0);

        // en toggling holds the state
        do_load(5'd4, 16'h3, 16'h1, 1'b0, 1'b0);
        en = 1'b1; cyc("tog1"); check("tog1.seq", 32'(seq), 32'h8);
        en = 1'b0; cyc("tog0a"); check("tog0a.seq", 32'(seq), 32'h8);
        check("tog0a.done", 32'(period_done), 32'h0);
        cyc("tog0b"); check("tog0b.seq", 32'(seq), 32'h8);
        en = 1'b1; cyc("tog1b"); check("tog1b.seq", 32'(seq), 32'h4);

        // load and en together: restart, no advance; period restarts too
        cyc("pre"); cyc("pre");
        do_load(5'd4, 16'h3, 16'h3, 1'b0, 1'b1);
        check("ldEn.seq", 32'(seq), 32'h3);
        en = 1'b1;
        first_done = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc("ldEn_run");
            if (period_done && first_done == 0) first_done = i;
        end
        check("ldEn.first_done", 32'(first_done), 32'd15);

        // length clamps
        do_load(5'd1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        check("n1.seq", 32'(seq), 32'h3);
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc("n1_run");
        do_load(5'd20, 16'hB400, 16'hFFFF, 1'b0, 1'b0);
        check("n20.seq", 32'(seq), 32'hFFFF);
        en = 1'b1;
        for (int i = 0; i < 20; i++) cyc("n20_run");
        do_load(5'd5, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc("n5_run");
            check("n5.high_zero", 32'(seq[15:5]), 32'h0);
        end

        // Polynomial 0 never returns to seed 1: period_len is held
        do_load(5'd4, 16'h3, 16'h1, 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 15; i++) cyc("full");
        do_load(5'd4, 16'h0, 16'h1, 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 20; i++) cyc("stuck");
        check("stuck.period_len", 32'(period_len), 32'd15);

        // Asynchronous reset between edges
        do_load(5'd4, 16'h3, 16'h0, 1'b0, 1'b0);
        en = 1'b1; cyc("pre_rst");
        en = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("arst.seq", 32'(seq), 32'h1);
        check("arst.period_len", 32'(period_len), 32'h0);
        check("arst.lockup", 32'(lockup), 32'h0);
        m_reset();
        #1 reset_n = 1'b1;
        cyc("post_rst");

        // Galois periods. Tap mask 0xB (poly 0x3 with the top tap) closes
        // after 7 steps. Tap mask 0x9 (poly 0x1) gives the full 15.
        do_load(5'd4, 16'h3, 16'h1, 1'b1, 1'b0);
        en = 1'b1; first_done = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc("gal3");
            if (period_done && first_done == 0) first_done = i;
        end
        check("gal3.first_done", 32'(first_done), 32'd7);
        check("gal3.period_len", 32'(period_len), 32'd7);
        do_load(5'd4, 16'h1, 16'h1, 1'b1, 1'b0);
        en = 1'b1; first_done = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc("gal1");
            if (period_done && first_done == 0) first_done = i;
        end
        check("gal1.first_done", 32'(first_done), 32'd15);
        check("gal1.period_len", 32'(period_len), 32'd15);

        // Randomized run. Config inputs change every cycle but take effect
        // only on load.
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            cfg_n    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(2, 5));
            cfg_poly = 16'($urandom);
            cfg_seed = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cfg_mode = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
